pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipelined MIPS control unit. It decodes Opcode/Funct in the Decode stage and carries the control bundle through the ID/EX, EX/MEM and MEM/WB pipeline registers, with flush and stall support. It also adds a parametrised multi-cycle MULT/DIV busy tracker that raises a decode-stage stall request for HI/LO hazards. It sits between the instruction register (IF/ID) and the datapath, beside the hazard unit, and replaces the combinational control decoder plus the separate control pipeline registers.

## Interface
- ALUCTRL_W, 4, width of the ALU control field (must be >= 4)
- MD_LATENCY, 8, cycles a MULT/DIV occupies the HI/LO unit (2..255)
- ENABLE_MD, 1, 0 removes MULT/DIV/MFHI/MFLO support (those decode as illegal; MDBusy tied 0)
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- Opcode  in  6  instruction[31:26] from IF/ID
- Funct  in  6  instruction[5:0] from IF/ID
- StallE  in  1  hold the ID/EX register; a bubble enters EX/MEM
- FlushE  in  1  clear the ID/EX register (bubble)
- BranchD, Branch_beqD, Branch_bneD, JumpD  out  1 each  combinational D-stage controls
- IllegalD  out  1  combinational: opcode/funct not supported
- MDStallD  out  1  combinational: the D instruction must wait for the HI/LO unit
- RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ALUSelectShiftE  out  1 each  registered
- ALUCtrlE  out  ALUCTRL_W  registered
- MDStartE  out  1  registered: MULT/DIV in EX, first cycle
- MDOpE  out  1  registered: 0 = MULT, 1 = DIV
- RegWriteM, MemtoRegM, MemWriteM  out  1 each  registered
- RegWriteW, MemtoRegW  out  1 each  registered
- MDBusy  out  1  HI/LO unit occupied

## Operation
- Decode, with all other fields 0:
  - R-type 000000: RegWrite=1, RegDst=1, ALUCtrl from Funct
  - lw 100011: RegWrite=1, ALUSrc=1, MemtoReg=1, ADD
  - sw 101011: MemWrite=1, ALUSrc=1, ADD
  - beq 000100: Branch_beq=1, SUB
  - bne 000101: Branch_bne=1, SUB
  - addi 001000: RegWrite=1, ALUSrc=1, ADD
  - andi 001100: as addi but AND
  - ori 001101: as addi but OR
  - slti 001010: as addi but SLT
  - j 000010: Jump=1
- BranchD = Branch_beqD | Branch_bneD.
- ALUCtrl codes (zero-extended to ALUCTRL_W): AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, SLL 1000, SRL 1001.
- Funct decode: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT, 000000 SLL, 000010 SRL. ALUSelectShift=1 for SLL/SRL only.
- MD funct values (RegWrite=0 for MULT/DIV):
  - 011000 MULT: MDStart, MDOp=0
  - 011010 DIV: MDStart, MDOp=1
  - 010000 MFHI and 010010 MFLO: RegWrite=1, RegDst=1, ALUCtrl=ADD
- Any other opcode or funct: IllegalD=1 and all controls 0, so the instruction is a NOP.
- ID/EX update, in priority order:
  - FlushE: all E outputs 0
  - else StallE: hold
  - else load the decoded bundle
- EX/MEM: if StallE, load 0 (bubble); else copy from E. MEM/WB always copies from M.
- MD tracker: an 8-bit down-counter.
  - When MDStartE=1 and StallE=0, the counter loads MD_LATENCY and MDBusy=1.
  - Each following cycle it decrements; MDBusy = (count != 0).
- MDStallD = MDBusy & (D is MULT, DIV, MFHI or MFLO). The hazard unit must then freeze IF/ID and pulse FlushE.
- A MULT in E while the counter is nonzero cannot occur, because MDStallD blocks it. If it does occur, the counter reloads.

## Timing
- D outputs are combinational from Opcode/Funct with zero latency.
- E/M/W outputs are 1/2/3 cycles after the D instruction is accepted.
- MDBusy rises the cycle after MDStartE is accepted and stays high exactly MD_LATENCY cycles.
- An MFLO waiting in D leaves D on the first cycle with MDBusy=0.
- Reset (asynchronous, any cycle, including mid-MD operation): every registered output = 0, counter = 0, MDBusy = 0. The first edge after release loads the normal bundle.
- FlushE and StallE together: flush wins.

## Test plan
- lw (0x23) in D, no stall → cycle+1: RegWriteE=1, ALUSrcE=1, MemtoRegE=1, ALUCtrlE=0010; cycle+2: MemtoRegM=1; cycle+3: RegWriteW=1, MemtoRegW=1.
- R-type Funct 0x02 (SRL) → ALUCtrlE=1001, ALUSelectShiftE=1, RegDstE=1. bne → Branch_bneD=1, BranchD=1, ALUCtrlE=0110.
- MD_LATENCY=4: MULT accepted, then MFLO in D → MDBusy high 4 cycles, MDStallD high for those 4 cycles, MFLO reaches E on cycle 5 with RegWriteE=1.
- sw in D with FlushE=1 → E all 0, next cycle MemWriteM=0. StallE=1 with add in E → E holds, M bubble (RegWriteM=0).
- Opcode 0x3F → IllegalD=1, all controls 0. ENABLE_MD=0 with DIV → IllegalD=1, MDBusy stays 0.
- rst_n low for 1 cycle while MDBusy=1 and count 3 → all outputs 0 immediately (asynchronous), MDBusy=0 after release.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipelined MIPS control unit: decodes the IF/ID instruction and carries the
// control bundle through ID/EX, EX/MEM and MEM/WB, plus a MULT/DIV HI/LO busy tracker.
module pipe_ctrl #(
    parameter int ALUCTRL_W  = 4,
    parameter int MD_LATENCY = 8,
    parameter bit ENABLE_MD  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [5:0]           Opcode,
    input  logic [5:0]           Funct,
    input  logic                 StallE,
    input  logic                 FlushE,
    output logic                 BranchD,
    output logic                 Branch_beqD,
    output logic                 Branch_bneD,
    output logic                 JumpD,
    output logic                 IllegalD,
    output logic                 MDStallD,
    output logic                 RegWriteE,
    output logic                 MemtoRegE,
    output logic                 MemWriteE,
    output logic                 ALUSrcE,
    output logic                 RegDstE,
    output logic                 ALUSelectShiftE,
    output logic [ALUCTRL_W-1:0] ALUCtrlE,
    output logic                 MDStartE,
    output logic                 MDOpE,
    output logic                 RegWriteM,
    output logic                 MemtoRegM,
    output logic                 MemWriteM,
    output logic                 RegWriteW,
    output logic                 MemtoRegW,
    output logic                 MDBusy
);

    localparam logic [ALUCTRL_W-1:0] ALU_AND = ALUCTRL_W'(4'b0000);
    localparam logic [ALUCTRL_W-1:0] ALU_OR  = ALUCTRL_W'(4'b0001);
    localparam logic [ALUCTRL_W-1:0] ALU_ADD = ALUCTRL_W'(4'b0010);
    localparam logic [ALUCTRL_W-1:0] ALU_SUB = ALUCTRL_W'(4'b0110);
    localparam logic [ALUCTRL_W-1:0] ALU_SLT = ALUCTRL_W'(4'b0111);
    localparam logic [ALUCTRL_W-1:0] ALU_SLL = ALUCTRL_W'(4'b1000);
    localparam logic [ALUCTRL_W-1:0] ALU_SRL = ALUCTRL_W'(4'b1001);
    localparam logic [7:0]           MD_LAT  = 8'(MD_LATENCY);

    typedef struct packed {
        logic                 reg_write;
        logic                 mem_to_reg;
        logic                 mem_write;
        logic                 alu_src;
        logic                 reg_dst;
        logic                 alu_shift;
        logic [ALUCTRL_W-1:0] alu_ctrl;
        logic                 md_start;
        logic                 md_op;
    } ctl_t;

    ctl_t       dec_ctl;
    logic       dec_beq, dec_bne, dec_jump, dec_illegal, dec_is_md;
    ctl_t       e_d, e_q;
    logic [2:0] m_d, m_q;
    logic [1:0] w_d, w_q;
    logic [7:0] count_d, count_q;
    logic       md_busy;

    always_comb begin
        dec_ctl     = '0;
        dec_beq     = 1'b0;
        dec_bne     = 1'b0;
        dec_jump    = 1'b0;
        dec_illegal = 1'b0;
        dec_is_md   = 1'b0;
        case (Opcode)
            6'b000000: begin
                dec_ctl.reg_write = 1'b1;
                dec_ctl.reg_dst   = 1'b1;
                case (Funct)
                    6'b100000: dec_ctl.alu_ctrl = ALU_ADD;
                    6'b100010: dec_ctl.alu_ctrl = ALU_SUB;
                    6'b100100: dec_ctl.alu_ctrl = ALU_AND;
                    6'b100101: dec_ctl.alu_ctrl = ALU_OR;
                    6'b101010: dec_ctl.alu_ctrl = ALU_SLT;
                    6'b000000: begin
                        dec_ctl.alu_ctrl  = ALU_SLL;
                        dec_ctl.alu_shift = 1'b1;
                    end
                    6'b000010: begin
                        dec_ctl.alu_ctrl  = ALU_SRL;
                        dec_ctl.alu_shift = 1'b1;
                    end
                    // MULT/DIV write only HI/LO, never the register file
                    6'b011000, 6'b011010: begin
                        dec_ctl.reg_write = 1'b0;
                        dec_ctl.reg_dst   = 1'b0;
                        dec_ctl.md_start  = 1'b1;
                        dec_ctl.md_op     = Funct[1];
                        dec_is_md         = 1'b1;
                        dec_illegal       = !ENABLE_MD;
                    end
                    6'b010000, 6'b010010: begin
                        dec_ctl.alu_ctrl = ALU_ADD;
                        dec_is_md        = 1'b1;
                        dec_illegal      = !ENABLE_MD;
                    end
                    default: dec_illegal = 1'b1;
                endcase
            end
            6'b100011: begin
                dec_ctl.reg_write  = 1'b1;
                dec_ctl.alu_src    = 1'b1;
                dec_ctl.mem_to_reg = 1'b1;
                dec_ctl.alu_ctrl   = ALU_ADD;
            end
            6'b101011: begin
                dec_ctl.mem_write = 1'b1;
                dec_ctl.alu_src   = 1'b1;
                dec_ctl.alu_ctrl  = ALU_ADD;
            end
            6'b000100: begin
                dec_beq          = 1'b1;
                dec_ctl.alu_ctrl = ALU_SUB;
            end
            6'b000101: begin
                dec_bne          = 1'b1;
                dec_ctl.alu_ctrl = ALU_SUB;
            end
            6'b001000, 6'b001100, 6'b001101, 6'b001010: begin
                dec_ctl.reg_write = 1'b1;
                dec_ctl.alu_src   = 1'b1;
                case (Opcode[2:0])
                    3'b100:  dec_ctl.alu_ctrl = ALU_AND;
                    3'b101:  dec_ctl.alu_ctrl = ALU_OR;
                    3'b010:  dec_ctl.alu_ctrl = ALU_SLT;
                    default: dec_ctl.alu_ctrl = ALU_ADD;
                endcase
            end
            6'b000010: dec_jump = 1'b1;
            default:   dec_illegal = 1'b1;
        endcase
        // an unsupported instruction must travel down the pipe as a pure NOP
        if (dec_illegal) begin
            dec_ctl   = '0;
            dec_beq   = 1'b0;
            dec_bne   = 1'b0;
            dec_jump  = 1'b0;
            dec_is_md = 1'b0;
        end
    end

    always_comb begin
        e_d = e_q;
        if (FlushE) begin
            e_d = '0;
        end else if (!StallE) begin
            e_d = dec_ctl;
        end
        m_d     = StallE ? 3'b000 : {e_q.reg_write, e_q.mem_to_reg, e_q.mem_write};
        w_d     = m_q[2:1];
        count_d = count_q;
        if (ENABLE_MD && e_q.md_start && !StallE) begin
            count_d = MD_LAT;
        end else if (count_q != 8'd0) begin
            count_d = count_q - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q     <= '0;
            m_q     <= '0;
            w_q     <= '0;
            count_q <= '0;
        end else begin
            e_q     <= e_d;
            m_q     <= m_d;
            w_q     <= w_d;
            count_q <= count_d;
        end
    end

    assign md_busy         = ENABLE_MD && (count_q != 8'd0);
    assign MDBusy          = md_busy;
    assign MDStallD        = md_busy & dec_is_md;
    assign Branch_beqD     = dec_beq;
    assign Branch_bneD     = dec_bne;
    assign BranchD         = dec_beq | dec_bne;
    assign JumpD           = dec_jump;
    assign IllegalD        = dec_illegal;
    assign RegWriteE       = e_q.reg_write;
    assign MemtoRegE       = e_q.mem_to_reg;
    assign MemWriteE       = e_q.mem_write;
    assign ALUSrcE         = e_q.alu_src;
    assign RegDstE         = e_q.reg_dst;
    assign ALUSelectShiftE = e_q.alu_shift;
    assign ALUCtrlE        = e_q.alu_ctrl;
    assign MDStartE        = e_q.md_start;
    assign MDOpE           = e_q.md_op;
    assign RegWriteM       = m_q[2];
    assign MemtoRegM       = m_q[1];
    assign MemWriteM       = m_q[0];
    assign RegWriteW       = w_q[1];
    assign MemtoRegW       = w_q[0];

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: two instances (MD enabled / disabled) driven
// in parallel and compared against a stage-level reference model of the decode rules.
module tb_pipe_ctrl;

    localparam int LAT = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       stall_e = 1'b0;
    logic       flush_e = 1'b0;

    always #5 clk = ~clk;

    logic br0, beq0, bne0, j0, ill0, mds0, rwe0, mtre0, mwe0, srce0, dste0, she0, mse0, moe0;
    logic rwm0, mtrm0, mwm0, rww0, mtrw0, busy0;
    logic [3:0] alue0;
    logic br1, beq1, bne1, j1, ill1, mds1, rwe1, mtre1, mwe1, srce1, dste1, she1, mse1, moe1;
    logic rwm1, mtrm1, mwm1, rww1, mtrw1, busy1;
    logic [3:0] alue1;

    pipe_ctrl #(.ALUCTRL_W(4), .MD_LATENCY(LAT), .ENABLE_MD(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .Opcode(opcode), .Funct(funct),
        .StallE(stall_e), .FlushE(flush_e),
        .BranchD(br0), .Branch_beqD(beq0), .Branch_bneD(bne0), .JumpD(j0),
        .IllegalD(ill0), .MDStallD(mds0),
        .RegWriteE(rwe0), .MemtoRegE(mtre0), .MemWriteE(mwe0), .ALUSrcE(srce0),
        .RegDstE(dste0), .ALUSelectShiftE(she0), .ALUCtrlE(alue0),
        .MDStartE(mse0), .MDOpE(moe0),
        .RegWriteM(rwm0), .MemtoRegM(mtrm0), .MemWriteM(mwm0),
        .RegWriteW(rww0), .MemtoRegW(mtrw0), .MDBusy(busy0)
    );

    pipe_ctrl #(.ALUCTRL_W(4), .MD_LATENCY(LAT), .ENABLE_MD(1'b0)) dut_nomd (
        .clk(clk), .rst_n(rst_n), .Opcode(opcode), .Funct(funct),
        .StallE(stall_e), .FlushE(flush_e),
        .BranchD(br1), .Branch_beqD(beq1), .Branch_bneD(bne1), .JumpD(j1),
        .IllegalD(ill1), .MDStallD(mds1),
        .RegWriteE(rwe1), .MemtoRegE(mtre1), .MemWriteE(mwe1), .ALUSrcE(srce1),
        .RegDstE(dste1), .ALUSelectShiftE(she1), .ALUCtrlE(alue1),
        .MDStartE(mse1), .MDOpE(moe1),
        .RegWriteM(rwm1), .MemtoRegM(mtrm1), .MemWriteM(mwm1),
        .RegWriteW(rww1), .MemtoRegW(mtrw1), .MDBusy(busy1)
    );

    logic [4:0]  dv [2];
    logic [11:0] ev [2];
    logic [2:0]  mv [2];
    logic [1:0]  wv [2];
    logic        bv [2];
    logic        sv [2];

    assign dv[0] = {ill0, beq0, bne0, j0, br0};
    assign dv[1] = {ill1, beq1, bne1, j1, br1};
    assign ev[0] = {rwe0, mtre0, mwe0, srce0, dste0, she0, alue0, mse0, moe0};
    assign ev[1] = {rwe1, mtre1, mwe1, srce1, dste1, she1, alue1, mse1, moe1};
    assign mv[0] = {rwm0, mtrm0, mwm0};
    assign mv[1] = {rwm1, mtrm1, mwm1};
    assign wv[0] = {rww0, mtrw0};
    assign wv[1] = {rww1, mtrw1};
    assign bv[0] = busy0;
    assign bv[1] = busy1;
    assign sv[0] = mds0;
    assign sv[1] = mds1;

    // Reference model: one control word per stage and the cycle at which HI/LO frees up
    typedef struct packed {
        logic        illegal;
        logic        beq;
        logic        bne;
        logic        jump;
        logic [11:0] ctl;
    } dec_t;

    logic [11:0] e_m [2];
    logic [11:0] m_m [2];
    logic [11:0] w_m [2];
    int          busy_end [2];
    int          cyc;
    int          n_cmp;
    int          n_fail;

    function automatic logic [11:0] mk(bit rw, bit mtr, bit mw, bit src, bit dst, bit sh,
                                       bit [3:0] alu, bit ms, bit mo);
        return {rw, mtr, mw, src, dst, sh, alu, ms, mo};
    endfunction

    function automatic dec_t ref_decode(logic [5:0] op, logic [5:0] fn, bit en);
        dec_t r;
        r = '0;
        case (op)
            6'h00: case (fn)
                6'h20: r.ctl = mk(1, 0, 0, 0, 1, 0, 4'b0010, 0, 0);
                6'h22: r.ctl = mk(1, 0, 0, 0, 1, 0, 4'b0110, 0, 0);
                6'h24: r.ctl = mk(1, 0, 0, 0, 1, 0, 4'b0000, 0, 0);
                6'h25: r.ctl = mk(1, 0, 0, 0, 1, 0, 4'b0001, 0, 0);
                6'h2A: r.ctl = mk(1, 0, 0, 0, 1, 0, 4'b0111, 0, 0);
                6'h00: r.ctl = mk(1, 0, 0, 0, 1, 1, 4'b1000, 0, 0);
                6'h02: r.ctl = mk(1, 0, 0, 0, 1, 1, 4'b1001, 0, 0);
                6'h18: if (en) r.ctl = mk(0, 0, 0, 0, 0, 0, 4'b0000, 1, 0); else r.illegal = 1'b1;
                6'h1A: if (en) r.ctl = mk(0, 0, 0, 0, 0, 0, 4'b0000, 1, 1); else r.illegal = 1'b1;
                6'h10, 6'h12:
                       if (en) r.ctl = mk(1, 0, 0, 0, 1, 0, 4'b0010, 0, 0); else r.illegal = 1'b1;
                default: r.illegal = 1'b1;
            endcase
            6'h23: r.ctl = mk(1, 1, 0, 1, 0, 0, 4'b0010, 0, 0);
            6'h2B: r.ctl = mk(0, 0, 1, 1, 0, 0, 4'b0010, 0, 0);
            6'h04: begin r.beq = 1'b1; r.ctl = mk(0, 0, 0, 0, 0, 0, 4'b0110, 0, 0); end
            6'h05: begin r.bne = 1'b1; r.ctl = mk(0, 0, 0, 0, 0, 0, 4'b0110, 0, 0); end
            6'h08: r.ctl = mk(1, 0, 0, 1, 0, 0, 4'b0010, 0, 0);
            6'h0C: r.ctl = mk(1, 0, 0, 1, 0, 0, 4'b0000, 0, 0);
            6'h0D: r.ctl = mk(1, 0, 0, 1, 0, 0, 4'b0001, 0, 0);
            6'h0A: r.ctl = mk(1, 0, 0, 1, 0, 0, 4'b0111, 0, 0);
            6'h02: r.jump = 1'b1;
            default: r.illegal = 1'b1;
        endcase
        return r;
    endfunction

    function automatic bit is_md(logic [5:0] op, logic [5:0] fn, bit en);
        return en && op == 6'h00 && (fn == 6'h18 || fn == 6'h1A || fn == 6'h10 || fn == 6'h12);
    endfunction

    task automatic chk(string tag, int i, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s dut%0d cyc=%0d observed=%0h expected=%0h", tag, i, cyc, obs, exp);
        end
    endtask

    task automatic check_d();
        dec_t d;
        for (int i = 0; i < 2; i++) begin
            d = ref_decode(opcode, funct, i == 0);
            chk("Dctl", i, 32'(dv[i]), 32'({d.illegal, d.beq, d.bne, d.jump, d.beq | d.bne}));
            chk("MDStallD", i, 32'(sv[i]), 32'((cyc < busy_end[i]) && is_md(opcode, funct, i == 0)));
        end
    endtask

    task automatic check_regs();
        for (int i = 0; i < 2; i++) begin
            chk("Ebundle", i, 32'(ev[i]), 32'(e_m[i]));
            chk("Mbundle", i, 32'(mv[i]), 32'(m_m[i][11:9]));
            chk("Wbundle", i, 32'(wv[i]), 32'(w_m[i][11:10]));
            chk("MDBusy", i, 32'(bv[i]), 32'(cyc < busy_end[i]));
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            e_m[i] = '0;
            m_m[i] = '0;
            w_m[i] = '0;
            busy_end[i] = 0;
        end
    endtask

    task automatic model_edge();
        dec_t d;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            d = ref_decode(opcode, funct, i == 0);
            if (e_m[i][1] && !stall_e) busy_end[i] = cyc + LAT;
            w_m[i] = m_m[i];
            m_m[i] = stall_e ? 12'd0 : e_m[i];
            if (flush_e) e_m[i] = '0;
            else if (!stall_e) e_m[i] = d.ctl;
        end
    endtask

    task automatic applyStimulus(logic [5:0] op, logic [5:0] fn, logic st, logic fl);
        opcode  = op;
        funct   = fn;
        stall_e = st;
        flush_e = fl;
        #1;
        check_d();
    endtask

    task automatic checkOutput();
        @(posedge clk);
        model_edge();
        #1;
        check_regs();
    endtask

    task automatic step(logic [5:0] op, logic [5:0] fn, logic st, logic fl);
        applyStimulus(op, fn, st, fl);
        checkOutput();
    endtask

    logic [5:0] ops [11];
    logic [5:0] fns [12];

    initial begin
        int stalls;
        bit left_d;
        n_cmp  = 0;
        n_fail = 0;
        cyc    = 0;
        model_reset();
        ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h02, 6'h3F};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02, 6'h18, 6'h1A, 6'h10, 6'h12, 6'h3F};

        #3;
        check_regs();
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] directed decode and pipeline steps");
        step(6'h23, 6'h15, 0, 0);
        step(6'h00, 6'h02, 0, 0);
        step(6'h05, 6'h00, 0, 0);
        step(6'h00, 6'h20, 0, 0);
        step(6'h2B, 6'h00, 0, 1);
        step(6'h00, 6'h20, 0, 0);
        step(6'h08, 6'h00, 1, 0);
        step(6'h08, 6'h00, 1, 1);
        step(6'h3F, 6'h20, 0, 0);
        step(6'h00, 6'h1A, 0, 0);
        step(6'h00, 6'h20, 0, 0);
        step(6'h00, 6'h20, 0, 0);

        $display("[TB] MULT followed by MFLO held in decode");
        step(6'h00, 6'h18, 0, 0);
        step(6'h08, 6'h00, 0, 0);
        stalls = 0;
        left_d = 1'b0;
        for (int k = 0; k < 10 && !left_d; k++) begin
            applyStimulus(6'h00, 6'h12, 0, 0);
            flush_e = mds0;
            if (mds0) stalls++;
            else left_d = 1'b1;
            checkOutput();
        end
        chk("MDStallCycles", 0, 32'(stalls), 32'(LAT));
        chk("MFLOLeftD", 0, 32'(left_d), 32'd1);
        step(6'h00, 6'h20, 0, 0);

        $display("[TB] asynchronous reset during a DIV");
        step(6'h00, 6'h1A, 0, 0);
        step(6'h00, 6'h20, 0, 0);
        step(6'h23, 6'h00, 0, 0);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_regs();
        @(posedge clk);
        #1;
        check_regs();
        @(negedge clk);
        rst_n = 1'b1;
        step(6'h23, 6'h00, 0, 0);
        step(6'h00, 6'h20, 0, 0);

        $display("[TB] randomized instruction stream");
        for (int k = 0; k < 300; k++) begin
            logic [5:0] op;
            logic [5:0] fn;
            op = ($urandom_range(9) == 0) ? 6'($urandom_range(63)) : ops[$urandom_range(10)];
            fn = ($urandom_range(9) == 0) ? 6'($urandom_range(63)) : fns[$urandom_range(11)];
            step(op, fn, ($urandom_range(7) == 0), ($urandom_range(7) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
